matmul_scheduler: RTL

MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

---
 rtl/matmul_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/matmul_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matmul_scheduler
// Brief    : Instruction scheduler for a 2x2 systolic MATMUL datapath. It issues
//            the weight/input load, MATMUL valid-window and store strobes,
//            waits for the accumulator full flags and reports sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_scheduler #(
    parameter int ADDR_W    = 13,
    parameter int MM_CYCLES = 5,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_opcode,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              acc1_full,
    input  logic              acc2_full,
    input  logic              clear_error,
    output logic              load_weight,
    output logic              load_input,
    output logic              valid,
    output logic              store,
    output logic [ADDR_W-1:0] base_address,
    output logic              done,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int CNT_MAX = (MM_CYCLES > TIMEOUT) ? MM_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0]       c_op_ldw   = 2'b00;
    localparam logic [1:0]       c_op_ldi   = 2'b01;
    localparam logic [1:0]       c_op_mm    = 2'b10;
    localparam logic [1:0]       c_op_st    = 2'b11;
    localparam logic [1:0]       c_err_oper = 2'b01;
    localparam logic [1:0]       c_err_tout = 2'b10;
    localparam logic [CNT_W-1:0] c_mm_last  = CNT_W'(MM_CYCLES);
    localparam logic [CNT_W-1:0] c_to_last  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDW   = 3'd1,
        S_LDI   = 3'd2,
        S_MM    = 3'd3,
        S_WAITF = 3'd4,
        S_ST    = 3'd5
    } state_t;

    state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic              r_w_loaded, w_w_loaded_nx;
    logic              r_i_loaded, w_i_loaded_nx;
    logic              r_acc1_seen, w_acc1_seen_nx;
    logic              r_acc2_seen, w_acc2_seen_nx;
    logic              w_ldw_nx, w_ldi_nx, w_valid_nx, w_store_nx, w_done_nx;
    logic              w_err_set;
    logic [1:0]        w_err_code_set;
    logic              w_accept;
    logic              w_acc1_eff, w_acc2_eff;

    assign w_accept   = instr_valid && (r_state == S_IDLE);
    // Flags seen in the current cycle count immediately, so done follows the
    // second flag by exactly one cycle.
    assign w_acc1_eff = r_acc1_seen || acc1_full;
    assign w_acc2_eff = r_acc2_seen || acc2_full;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_w_loaded_nx  = r_w_loaded;
        w_i_loaded_nx  = r_i_loaded;
        w_acc1_seen_nx = r_acc1_seen;
        w_acc2_seen_nx = r_acc2_seen;
        w_ldw_nx       = 1'b0;
        w_ldi_nx       = 1'b0;
        w_valid_nx     = 1'b0;
        w_store_nx     = 1'b0;
        w_done_nx      = 1'b0;
        w_err_set      = 1'b0;
        w_err_code_set = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (instr_opcode)
                        c_op_ldw: begin
                            w_state_nx    = S_LDW;
                            w_ldw_nx      = 1'b1;
                            w_done_nx     = 1'b1;
                            w_w_loaded_nx = 1'b1;
                        end
                        c_op_ldi: begin
                            w_state_nx    = S_LDI;
                            w_ldi_nx      = 1'b1;
                            w_done_nx     = 1'b1;
                            w_i_loaded_nx = 1'b1;
                        end
                        c_op_mm: begin
                            if (r_w_loaded && r_i_loaded) begin
                                w_state_nx = S_MM;
                                w_valid_nx = 1'b1;
                                w_cnt_nx   = CNT_W'(1);
                            end else begin
                                w_err_set      = 1'b1;
                                w_err_code_set = c_err_oper;
                            end
                        end
                        c_op_st: begin
                            w_state_nx = S_ST;
                            w_store_nx = 1'b1;
                            w_done_nx  = 1'b1;
                        end
                    endcase
                end
            end

            S_LDW, S_LDI, S_ST: begin
                w_state_nx = S_IDLE;
            end

            S_MM: begin
                w_acc1_seen_nx = w_acc1_eff;
                w_acc2_seen_nx = w_acc2_eff;
                if (r_cnt == c_mm_last) begin
                    w_state_nx = S_WAITF;
                    w_cnt_nx   = '0;
                end else begin
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end

            S_WAITF: begin
                if (w_acc1_eff && w_acc2_eff) begin
                    w_state_nx     = S_IDLE;
                    w_done_nx      = 1'b1;
                    w_cnt_nx       = '0;
                    w_acc1_seen_nx = 1'b0;
                    w_acc2_seen_nx = 1'b0;
                    w_i_loaded_nx  = 1'b0;
                end else if (r_cnt == c_to_last) begin
                    w_state_nx     = S_IDLE;
                    w_err_set      = 1'b1;
                    w_err_code_set = c_err_tout;
                    w_cnt_nx       = '0;
                    w_acc1_seen_nx = 1'b0;
                    w_acc2_seen_nx = 1'b0;
                    w_i_loaded_nx  = 1'b0;
                end else begin
                    w_cnt_nx       = r_cnt + 1'b1;
                    w_acc1_seen_nx = w_acc1_eff;
                    w_acc2_seen_nx = w_acc2_eff;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_w_loaded   <= 1'b0;
            r_i_loaded   <= 1'b0;
            r_acc1_seen  <= 1'b0;
            r_acc2_seen  <= 1'b0;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            valid        <= 1'b0;
            store        <= 1'b0;
            done         <= 1'b0;
            base_address <= '0;
            error        <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_w_loaded  <= w_w_loaded_nx;
            r_i_loaded  <= w_i_loaded_nx;
            r_acc1_seen <= w_acc1_seen_nx;
            r_acc2_seen <= w_acc2_seen_nx;
            instr_ready <= (w_state_nx == S_IDLE);
            busy        <= (w_state_nx != S_IDLE);
            load_weight <= w_ldw_nx;
            load_input  <= w_ldi_nx;
            valid       <= w_valid_nx;
            store       <= w_store_nx;
            done        <= w_done_nx;
            if (w_accept) begin
                base_address <= instr_addr;
            end
            // First code is kept unless it is being cleared in the same cycle.
            if (w_err_set) begin
                error <= 1'b1;
                if (!error || clear_error) begin
                    err_code <= w_err_code_set;
                end
            end else if (clear_error) begin
                error    <= 1'b0;
                err_code <= 2'b00;
            end
        end
    end

endmodule
`default_nettype wire
